// File: rtl/imem_loader.sv
// imem_loader: packs a big-endian byte stream into 32-bit instruction words, writes them
// to consecutive instruction-memory addresses and holds the CPU until the load completes.
// Optional trailing XOR checksum byte and err output are enabled by IMEM_LOADER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | after reset, waiting for start; CPU held
// LOAD  | accepting program bytes and writing words; CPU held
// DONE  | program loaded; CPU released (held while err=1)
module imem_loader #(
  parameter int          ADDR_W    = 16,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic              err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_ZERO = '0;

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [ADDR_W:0]   word_cnt;
  logic [31:0]       word_buf;
  logic              wr_pend;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
  logic              csum_got;
  logic              csum_bad;
`endif

  wire accept = in_valid && in_ready && (state == S_LOAD);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      byte_cnt  <= 2'd0;
      word_cnt  <= '0;
      word_buf  <= '0;
      wr_pend   <= 1'b0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum      <= 8'd0;
      csum_got  <= 1'b0;
      csum_bad  <= 1'b0;
      err       <= 1'b0;
`endif
    end else begin
      // Word assembled at edge N is strobed out at edge N+1.
      mem_we  <= wr_pend;
      wr_pend <= 1'b0;
      if (mem_we) mem_addr <= mem_addr + ADDR_ONE;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            word_cnt <= len;
            mem_addr <= BASE;
            byte_cnt <= 2'd0;
            word_buf <= '0;
            done     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= 8'd0;
            csum_got <= 1'b0;
            csum_bad <= 1'b0;
            err      <= 1'b0;
`endif
            if (len == CNT_ZERO) begin
              state    <= S_DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              cpu_hold <= 1'b0;
              in_ready <= 1'b0;
            end else begin
              state    <= S_LOAD;
              busy     <= 1'b1;
              cpu_hold <= 1'b1;
              in_ready <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (accept) begin
            if (word_cnt != CNT_ZERO) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              csum <= csum ^ in_data;
`endif
              // ~byte_cnt selects byte lane 3-k, so byte 0 lands in [31:24].
              word_buf[{~byte_cnt, 3'b000} +: 8] <= in_data;
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd3) begin
                mem_wdata <= {word_buf[31:8], in_data};
                wr_pend   <= 1'b1;
                word_cnt  <= word_cnt - CNT_ONE;
`ifndef IMEM_LOADER_CHECKSUM_EN
                // No more bytes are wanted once the last word is complete.
                if (word_cnt == CNT_ONE) in_ready <= 1'b0;
`endif
              end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            else begin
              csum_got <= 1'b1;
              csum_bad <= ((csum ^ in_data) != 8'd0);
              in_ready <= 1'b0;
            end
`endif
          end

`ifdef IMEM_LOADER_CHECKSUM_EN
          if (csum_got && !wr_pend && !mem_we && (word_cnt == CNT_ZERO)) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            err      <= csum_bad;
            cpu_hold <= csum_bad;
          end
`else
          if (mem_we && (word_cnt == CNT_ZERO)) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end
`endif
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface that the pipelined processor reads at fetch.
- Accepts a byte stream from a host/bench and packs it into 32-bit big-endian instruction words.
- Writes the words into instruction memory at consecutive word addresses.
- Holds the processor in reset until the program is fully loaded, then releases it.

Parameters:
ADDR_W, 16, instruction-memory word-address width (65536 words).
BASE_ADDR, 0, first word address written on each load.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous, active-low reset.
start  input  1  one-cycle pulse; begins a load of len words.
len  input  ADDR_W+1  number of words to load; sampled when start is accepted.
in_valid  input  1  in_data holds a valid byte.
in_data  input  8  program byte, most-significant byte of each word first.
in_ready  output  1  loader accepts a byte this cycle.
mem_we  output  1  instruction-memory write strobe, one cycle per word.
mem_addr  output  ADDR_W  word address for mem_we.
mem_wdata  output  32  instruction word for mem_we.
cpu_hold  output  1  active-high reset/hold to the processor.
busy  output  1  load in progress.
done  output  1  last load completed; level signal.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State becomes IDLE.
  - in_ready, mem_we, busy and done are 0; mem_addr and mem_wdata are 0.
  - cpu_hold is 1.
  - Byte counter, word counter and partial word are cleared.
- States:
  - IDLE:
    - start=1 latches len into the word counter, sets mem_addr to BASE_ADDR and clears done.
    - Next state is LOAD, or DONE if len=0.
  - LOAD:
    - busy=1, cpu_hold=1, in_ready=1.
    - A byte is accepted on each edge where in_valid=1 and in_ready=1.
    - Byte k of a word (k=0..3) goes to bits [31-8k -: 8].
  - DONE:
    - done=1, busy=0, in_ready=0, cpu_hold=0.
    - start=1 restarts the load exactly as from IDLE: cpu_hold returns to 1 in the next cycle and done clears.
- Write timing:
  - The 4th byte of a word is accepted at edge N. At edge N+1, mem_we=1 for exactly one cycle, with mem_wdata holding the full word and mem_addr its address.
  - mem_addr increments by 1 after each write and wraps modulo 2^ADDR_W; wrap is silent.
  - in_ready stays 1 during the write cycle, so back-to-back bytes run at 1 byte/cycle with no stall.
- Completion: after the write of word len-1, the state moves to DONE at the next edge.
  - cpu_hold falls and done rises together, 2 cycles after the last byte is accepted.
- Boundary cases:
  - Gaps in in_valid: no effect other than delay.
  - Bytes with in_valid=1 outside LOAD are not accepted; in_ready=0 there.
  - start during LOAD is ignored.
  - len=0: no writes; DONE one cycle after start.
  - len above 2^ADDR_W: addresses wrap and later words overwrite earlier ones.
  - Reset mid-word: the partial word is discarded, no write, cpu_hold=1.
  - Reset in the same cycle as a pending write: reset wins, mem_we=0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - After the last word, LOAD accepts one extra checksum byte: the XOR of all program bytes.
  - The state then moves to DONE.
  - Output err (1 bit) is set in DONE if the checksum mismatches, and cleared on start and on reset.
  - cpu_hold stays 1 while err=1.
- When not defined: no err port and no checksum byte; behaviour is as above.

Test Plan:
- 19-word program, 76 bytes streamed back-to-back, BASE_ADDR=0:
  - 19 mem_we pulses, addresses 0..18.
  - Word 5 = 0x00001020, word 18 = 0x08000006.
  - cpu_hold falls 2 cycles after the last byte.
- Same program with in_valid toggling 1-0-0-1:
  - Identical write contents and addresses, writes delayed only.
- start with len=0:
  - No mem_we; done=1 and cpu_hold=0 one cycle after start.
- Reset (rst=0) after 2 bytes of word 3:
  - No write for word 3; busy=0, cpu_hold=1.
  - After a new start with len=1 and bytes AC 14 03 E8: a single write of 0xAC1403E8 to address 0.
- BASE_ADDR=65534, len=3:
  - Writes to 65534, 65535, 0.
- Checksum, IMEM_LOADER_CHECKSUM_EN defined, one word 00 00 10 20:
  - Checksum byte 0x30 gives err=0 and cpu_hold=0.
  - Checksum byte 0x31 gives err=1 and cpu_hold=1.
